// File: rtl/up_loader_pkg.sv
// Shared definitions for the up_core program loader: image geometry, state codes
// and the checksum accumulator.
package up_loader_pkg;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/up_loader_ram.sv
// Image buffer: DEPTH x 8, synchronous write and synchronous read, contents not reset.
module up_loader_ram
  import up_loader_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/up_loader.sv
// Buffers a program image from a byte stream and replays it into up_core as one
// contiguous load burst, highest address first, with fill count and checksum.
module up_loader
  import up_loader_pkg::*;
#(
  parameter int unsigned GAP = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start,
  input  logic        abort,
  output logic        load,
  output logic [7:0]  load_data,
  output logic        busy,
  output logic        done,
  output logic [AW:0] fill_count,
  output logic [7:0]  checksum
);

  localparam int unsigned GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  state_t        state_q, state_d;
  logic [AW:0]   fill_q, fill_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_live_q, rd_live_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          load_q, load_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_ready_q, in_ready_d;

  logic          hs_c;
  logic          we_c;
  logic [7:0]    rdata;

  assign hs_c = in_valid & in_ready_q;
  assign we_c = hs_c & ~abort;

  // Read port is addressed with the next counter value so each byte lands one cycle later.
  up_loader_ram u_ram (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (fill_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_addr_d),
    .rdata_o (rdata)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      fill_q     <= '0;
      csum_q     <= '0;
      rd_addr_q  <= '0;
      rd_live_q  <= 1'b0;
      gap_q      <= '0;
      load_q     <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      csum_q     <= csum_d;
      rd_addr_q  <= rd_addr_d;
      rd_live_q  <= rd_live_d;
      gap_q      <= gap_d;
      load_q     <= load_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state and output logic; abort overrides everything in its cycle.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    csum_d    = csum_q;
    rd_addr_d = rd_addr_q;
    rd_live_d = rd_live_q;
    gap_d     = gap_q;
    load_d    = 1'b0;
    data_d    = '0;
    done_d    = 1'b0;

    if (abort) begin
      state_d   = ST_IDLE;
      fill_d    = '0;
      csum_d    = '0;
      rd_live_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FILL: begin
          if (hs_c) begin
            fill_d  = fill_q + (AW+1)'(1);
            csum_d  = (state_q == ST_IDLE) ? in_data : csum_add(csum_q, in_data);
            state_d = ST_FILL;
          end
          if (start || (fill_d == (AW+1)'(DEPTH))) begin
            state_d   = ST_STREAM;
            rd_live_d = 1'b0;
          end
        end
        ST_STREAM: begin
          if (!rd_live_q) begin
            rd_addr_d = AW'(DEPTH - 1);
            rd_live_d = 1'b1;
          end else begin
            load_d = 1'b1;
            data_d = rdata;
            if (rd_addr_q == '0) begin
              state_d   = ST_HOLD;
              gap_d     = '0;
              rd_live_d = 1'b0;
            end else begin
              rd_addr_d = rd_addr_q - AW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (gap_q == GW'(GAP)) begin
            done_d  = 1'b1;
            fill_d  = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    in_ready_d = (state_d == ST_IDLE) ||
                 ((state_d == ST_FILL) && (fill_d < (AW+1)'(DEPTH)));
    busy_d     = (state_d == ST_STREAM) || (state_d == ST_HOLD);
  end

  assign in_ready   = in_ready_q;
  assign load       = load_q;
  assign load_data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fill_count = fill_q;
  assign checksum   = csum_q;

endmodule
